// File: rtl/tcam_sram_pkg.sv
// Shared types and constants for the TCAM SRAM port-0 controller.
package tcam_sram_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  // Controller phases: array clear after reset, then normal shared access.
  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  // One cycle of macro port-0 signals, csb/web active low.
  typedef struct packed {
    logic                  csb;
    logic                  web;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } sram_port0_t;

endpackage

// File: rtl/tcam_sram_rd_pipe.sv
// Read return pipeline: the macro needs one cycle after a read grant before
// its output is stable, so the grant is delayed two stages and the data is
// captured on the second one, giving an aligned valid/data pair.
module tcam_sram_rd_pipe
  import tcam_sram_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_grant,
  input  logic [WIDTH-1:0] sram_dout,
  output logic             rd_rvalid,
  output logic [WIDTH-1:0] rd_rdata
);

  logic stage1_valid;

  // Shift the grant through two stages and latch macro data on the second.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_valid <= 1'b0;
      rd_rvalid    <= 1'b0;
      rd_rdata     <= '0;
    end else begin
      stage1_valid <= rd_grant;
      rd_rvalid    <= stage1_valid;
      if (stage1_valid) begin
        rd_rdata <= sram_dout;
      end
    end
  end

endmodule

// File: rtl/tcam_sram_port_ctrl.sv
// Port-0 (1RW) controller for one sky130 32x256 SRAM macro in the TCAM
// wrapper: zero-fills the array after reset, then shares the port between a
// config-side write requester and a search-side read requester.
module tcam_sram_port_ctrl
  import tcam_sram_pkg::*;
#(
  parameter int ADDR_WIDTH    = tcam_sram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = tcam_sram_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS    = tcam_sram_pkg::NUM_WMASKS,
  parameter int STARVE_LIMIT  = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WMASKS-1:0] wr_mask,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] STARVE_MAX = WW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [WW-1:0]         wr_wait;
  logic                  run_active;
  logic                  init_active;
  logic                  starve;
  logic                  wr_grant;
  logic                  rd_grant;
  sram_port0_t           port;

  // Reset is synchronous but the outputs must already read as idle while it
  // is held, so the state decode is qualified with rst directly.
  assign run_active  = (state == RUN) && !rst;
  assign init_active = (state == INIT) && !rst;
  assign starve      = (wr_wait >= STARVE_MAX);

  // Reads win by default; a write that has lost STARVE_LIMIT times in a row
  // takes the port. The two readies are mutually exclusive when both request.
  assign rd_ready  = run_active && !(wr_valid && starve);
  assign wr_ready  = run_active && (!rd_valid || starve);
  assign wr_grant  = wr_valid && wr_ready;
  assign rd_grant  = rd_valid && rd_ready && !wr_grant;
  assign init_done = run_active;

  // Init sequencer, phase control and write starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_cnt <= '0;
      wr_wait  <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_ADDR) begin
        state <= RUN;
      end
    end else begin
      if (wr_grant || !wr_valid) begin
        wr_wait <= '0;
      end else if (wr_wait != STARVE_MAX) begin
        wr_wait <= wr_wait + 1'b1;
      end
    end
  end

  // Macro port drive for this cycle; the macro registers these itself.
  always_comb begin
    port     = '0;
    port.csb = 1'b1;
    port.web = 1'b1;
    if (init_active) begin
      port.csb   = 1'b0;
      port.web   = 1'b0;
      port.wmask = '1;
      port.addr  = init_cnt;
      port.din   = '0;
    end else if (wr_grant) begin
      port.csb   = 1'b0;
      port.web   = 1'b0;
      port.wmask = wr_mask;
      port.addr  = wr_addr;
      port.din   = wr_data;
    end else if (rd_grant) begin
      port.csb  = 1'b0;
      port.web  = 1'b1;
      port.addr = rd_addr;
    end
  end

  assign sram_csb0   = port.csb;
  assign sram_web0   = port.web;
  assign sram_wmask0 = port.wmask;
  assign sram_addr0  = port.addr;
  assign sram_din0   = port.din;

  tcam_sram_rd_pipe #(
    .WIDTH(DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .rd_grant  (rd_grant),
    .sram_dout (sram_dout0),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata)
  );

endmodule

// File: tb/tb_tcam_sram_port_ctrl.sv
// Directed bench for tcam_sram_port_ctrl with a behavioural model of the
// sky130 macro port 0 (inputs registered on clk, read data valid next cycle).
module tb_tcam_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_addr;
  logic        rd_rvalid;
  logic [31:0] rd_rdata;
  logic        init_done;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  tcam_sram_port_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rd_rvalid   (rd_rvalid),
    .rd_rdata    (rd_rdata),
    .init_done   (init_done),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // Macro model: nonzero power-up contents so the zero-fill is observable.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    sram_dout0 = 32'h0;
  end

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic drive_idle();
    wr_valid = 1'b0; wr_addr = 8'h0; wr_data = 32'h0; wr_mask = 4'h0;
    rd_valid = 1'b0; rd_addr = 8'h0;
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    @(negedge clk); #1;
    checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("[TB] FAIL rst_csb got %b want 1", sram_csb0); end
    checks++; if (sram_web0 !== 1'b1) begin errors++; $display("[TB] FAIL rst_web got %b want 1", sram_web0); end
    checks++; if ({sram_wmask0, sram_addr0, sram_din0} !== 44'h0) begin errors++; $display("[TB] FAIL rst_port got %h/%h/%h want 0", sram_wmask0, sram_addr0, sram_din0); end
    checks++; if ({rd_rvalid, init_done, wr_ready, rd_ready} !== 4'b0) begin errors++; $display("[TB] FAIL rst_ctrl got %b want 0000", {rd_rvalid, init_done, wr_ready, rd_ready}); end
    checks++; if (rd_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h want 0", rd_rdata); end
  endtask

  // Walks the 256-cycle clear with requests optionally pending; neither may be accepted.
  task automatic test_zero_fill(input logic hold_requests);
    int bad = 0;
    if (hold_requests) begin
      drive_write(8'h33, 32'hFFFF_FFFF, 4'hF);
      rd_valid = 1'b1; rd_addr = 8'h44;
    end
    #1;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== 4'hF || sram_din0 !== 32'h0 ||
          sram_addr0 !== 8'(i) || wr_ready !== 1'b0 || rd_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        if (bad < 4) $display("[TB] FAIL init_cycle%0d got csb=%b web=%b m=%h a=%h d=%h wr=%b rr=%b done=%b want 0 0 f %h 0 0 0 0",
                              i, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, wr_ready, rd_ready, init_done, 8'(i));
        bad++;
      end
      @(negedge clk); #1;
    end
    drive_idle(); #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL init_done got %b want 1", init_done); end
    checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("[TB] FAIL init_extra_write csb got %b want 1", sram_csb0); end
    @(negedge clk);
  endtask

  task automatic test_read_zero();
    rd_valid = 1'b1; rd_addr = 8'h7F; #1;
    checks++; if (rd_ready !== 1'b1 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== 8'h7F) begin errors++; $display("[TB] FAIL rd7f_grant got rr=%b csb=%b web=%b a=%h want 1 0 1 7f", rd_ready, sram_csb0, sram_web0, sram_addr0); end
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd7f_early got %b want 0", rd_rvalid); end
    @(negedge clk); #1;
    checks++; if (rd_rvalid !== 1'b1 || rd_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd7f_data got v=%b d=%h want 1 00000000", rd_rvalid, rd_rdata); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    drive_write(8'h10, 32'hDEADBEEF, 4'hF); #1;
    checks++; if (wr_ready !== 1'b1 || sram_web0 !== 1'b0 || sram_addr0 !== 8'h10 || sram_din0 !== 32'hDEADBEEF || sram_wmask0 !== 4'hF) begin errors++; $display("[TB] FAIL wr_grant got wr=%b web=%b a=%h d=%h m=%h want 1 0 10 deadbeef f", wr_ready, sram_web0, sram_addr0, sram_din0, sram_wmask0); end
    @(negedge clk); drive_idle(); rd_valid = 1'b1; rd_addr = 8'h10; #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_rd_ready got %b want 1", rd_ready); end
    @(negedge clk); rd_valid = 1'b0; #1;
    checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_rd_early got %b want 0", rd_rvalid); end
    @(negedge clk); #1;
    checks++; if (rd_rvalid !== 1'b1 || rd_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_rd_data got v=%b d=%h want 1 deadbeef", rd_rvalid, rd_rdata); end
    @(negedge clk); #1;
    checks++; if (rd_rvalid !== 1'b0 || rd_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_rd_hold got v=%b d=%h want 0 deadbeef", rd_rvalid, rd_rdata); end
    @(negedge clk);
  endtask

  task automatic test_masked_write();
    drive_write(8'h10, 32'h11223344, 4'b0101);
    @(negedge clk); drive_idle(); rd_valid = 1'b1; rd_addr = 8'h10;
    @(negedge clk); rd_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (rd_rvalid !== 1'b1 || rd_rdata !== 32'hDE22BE44) begin errors++; $display("[TB] FAIL masked_data got v=%b d=%h want 1 de22be44", rd_rvalid, rd_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hA1; exp_data[1] = 32'hA2; exp_data[2] = 32'hA3;
    for (int i = 0; i < 3; i++) begin
      drive_write(8'(i + 1), exp_data[i], 4'hF);
      @(negedge clk);
    end
    drive_idle();
    for (int i = 0; i < 6; i++) begin
      rd_valid = (i < 3); rd_addr = 8'(i + 1); #1;
      if (i < 3) begin
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d got %b want 1", i, rd_ready); end
      end
      if (i >= 2 && i < 5) begin
        checks++; if (rd_rvalid !== 1'b1 || rd_rdata !== exp_data[i-2]) begin errors++; $display("[TB] FAIL b2b_data%0d got v=%b d=%h want 1 %h", i - 2, rd_rvalid, rd_rdata, exp_data[i-2]); end
      end else if (i == 5) begin
        checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail got %b want 0", rd_rvalid); end
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_starvation();
    rd_valid = 1'b1; rd_addr = 8'h10;
    drive_write(8'h20, 32'h0000_0055, 4'hF);
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 4) begin
        checks++; if (rd_ready !== 1'b1 || wr_ready !== 1'b0 || sram_web0 !== 1'b1 || sram_csb0 !== 1'b0) begin errors++; $display("[TB] FAIL starve_read%0d got rr=%b wr=%b web=%b csb=%b want 1 0 1 0", k, rd_ready, wr_ready, sram_web0, sram_csb0); end
      end else begin
        checks++; if (rd_ready !== 1'b0 || wr_ready !== 1'b1 || sram_web0 !== 1'b0 || sram_addr0 !== 8'h20) begin errors++; $display("[TB] FAIL starve_write got rr=%b wr=%b web=%b a=%h want 0 1 0 20", rd_ready, wr_ready, sram_web0, sram_addr0); end
      end
      @(negedge clk);
    end
    // A fresh write must lose again, showing the wait count was cleared.
    drive_write(8'h21, 32'h0000_0066, 4'hF); #1;
    checks++; if (wr_ready !== 1'b0 || rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL starve_clear got wr=%b rr=%b want 0 1", wr_ready, rd_ready); end
    @(negedge clk); drive_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    rd_valid = 1'b1; rd_addr = 8'h20; #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_grant got %b want 1", rd_ready); end
    @(negedge clk); rd_valid = 1'b0; rst = 1'b1; #1;
    checks++; if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || init_done !== 1'b0 || rd_ready !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_outputs got csb=%b web=%b done=%b rr=%b wr=%b want 1 1 0 0 0", sram_csb0, sram_web0, init_done, rd_ready, wr_ready); end
    @(negedge clk); #1;
    checks++; if (rd_rvalid !== 1'b0 || rd_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_dropped got v=%b d=%h want 0 00000000", rd_rvalid, rd_rdata); end
    rst = 1'b0;
    test_zero_fill(1'b1);
    rd_valid = 1'b1; rd_addr = 8'h10;
    @(negedge clk); rd_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (rd_rvalid !== 1'b1 || rd_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_reclear got v=%b d=%h want 1 00000000", rd_rvalid, rd_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    rst = 1'b0;
    test_zero_fill(1'b0);
    test_read_zero();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_starvation();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
